freq_div_ctrl: RTL and testbench

Run-time controller for the team's programmable clock divider. Accepts divide-ratio updates over a valid/ready handshake and applies them only at output-period boundaries, so the divided clock is glitch-free. Starts and stops the divider cleanly on an enable, and reports busy and configuration errors. Sits between the register/config logic and the divided-clock consumers.

---
 rtl/freq_div_ctrl_pkg.sv | 13 +
 rtl/freq_div_core.sv | 47 ++++
 rtl/freq_div_ctrl.sv | 99 +++++++++
 tb/tb_freq_div_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package freq_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } state_t;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/freq_div_core.sv
// Period counter and divided-clock generator: clk_o/tick_o are registered and aligned with cnt.
// No backpressure; clr forces cnt to 0 with clk_o low, run lets the counter advance.
module freq_div_core #(
  parameter int N = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         run,
  input  logic [N-1:0] div,
  output logic         boundary,
  output logic         clk_o,
  output logic         tick_o
);

  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nxt;
  logic [N-1:0] lo;

  assign lo       = div >> 1;
  assign boundary = run && !clr && (cnt == div - N'(1));

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (run) begin
      cnt_nxt = boundary ? '0 : cnt + N'(1);
    end
  end

  // Outputs are computed from the next count so they line up with cnt in
  // the same cycle. A ratio only changes when cnt_nxt is 0, which is always
  // in the low phase, so using the current lo here is safe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      clk_o  <= run && !clr && (cnt_nxt >= lo);
      tick_o <= run && !clr && (cnt_nxt == lo);
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Run-time divider controller: ratio updates are applied only at period boundaries.
// Start takes one cycle; a second ratio is stalled (cfg_ready_o low) until the first is applied.
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int N       = 10,
  parameter int DIV_RST = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         cfg_valid_i,
  input  logic [N-1:0] cfg_div_i,
  output logic         cfg_ready_o,
  output logic         clk_o,
  output logic         tick_o,
  output logic         busy_o,
  output logic         err_o
);

  state_t       state;
  logic [N-1:0] div_act;
  logic [N-1:0] div_pend;
  logic         pend_vld;
  logic         xfer;
  logic         xfer_ok;
  logic         boundary;

  assign cfg_ready_o = !pend_vld;
  assign busy_o      = (state != IDLE);
  assign xfer        = cfg_valid_i && cfg_ready_o;
  assign xfer_ok     = xfer && (cfg_div_i >= N'(DIV_MIN));

  freq_div_core #(
    .N (N)
  ) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (state == IDLE),
    .run      (busy_o),
    .div      (div_act),
    .boundary (boundary),
    .clk_o    (clk_o),
    .tick_o   (tick_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      div_act  <= N'(DIV_RST);
      div_pend <= '0;
      pend_vld <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      err_o <= xfer && !xfer_ok;
      unique case (state)
        IDLE: begin
          // A ratio accepted on the final stop boundary is still pending here.
          if (pend_vld) begin
            div_act  <= div_pend;
            pend_vld <= 1'b0;
          end else if (xfer_ok) begin
            div_act <= cfg_div_i;
          end
          if (en_i) state <= RUN;
        end
        RUN: begin
          if (xfer_ok) begin
            div_pend <= cfg_div_i;
            pend_vld <= 1'b1;
          end
          if (!en_i)        state <= STOP;
          else if (xfer_ok) state <= PEND;
        end
        PEND: begin
          if (boundary) begin
            div_act  <= div_pend;
            pend_vld <= 1'b0;
            state    <= en_i ? RUN : STOP;
          end
        end
        STOP: begin
          if (boundary && pend_vld) begin
            div_act  <= div_pend;
            pend_vld <= 1'b0;
          end
          if (xfer_ok) begin
            div_pend <= cfg_div_i;
            pend_vld <= 1'b1;
          end
          if (en_i)          state <= (xfer_ok || (pend_vld && !boundary)) ? PEND : RUN;
          else if (boundary) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios plus random traffic against a period-level model.
module tb_freq_div_ctrl;

  localparam int N       = 10;
  localparam int DIV_RST = 10;

  logic         clk_i       = 1'b0;
  logic         rst_i       = 1'b0;
  logic         en_i        = 1'b0;
  logic         cfg_valid_i = 1'b0;
  logic [N-1:0] cfg_div_i   = '0;
  logic         cfg_ready_o;
  logic         clk_o;
  logic         tick_o;
  logic         busy_o;
  logic         err_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: whether the divider is running, winding down, where it is in the
  // current period, the ratio in force and a ratio waiting for a boundary.
  bit m_active, m_stop, m_pend_vld, m_err;
  int m_pos, m_ratio, m_pend;

  always #5 clk_i = ~clk_i;

  freq_div_ctrl #(
    .N       (N),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_ready_o (cfg_ready_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  task automatic model_reset();
    m_active = 0; m_stop = 0; m_pend_vld = 0; m_err = 0;
    m_pos = 0; m_ratio = DIV_RST; m_pend = 0;
  endtask

  task automatic model_step();
    bit xfer, good, bnd;
    xfer  = cfg_valid_i && !m_pend_vld;
    good  = xfer && (int'(cfg_div_i) >= 2);
    m_err = xfer && (int'(cfg_div_i) < 2);
    if (!m_active) begin
      if (m_pend_vld) begin m_ratio = m_pend; m_pend_vld = 0; end
      else if (good) m_ratio = int'(cfg_div_i);
      m_pos = 0;
      if (en_i) begin m_active = 1; m_stop = 0; end
    end else begin
      bnd   = (m_pos == m_ratio - 1);
      m_pos = bnd ? 0 : m_pos + 1;
      if (m_stop) begin
        if (bnd && m_pend_vld) begin m_ratio = m_pend; m_pend_vld = 0; end
        if (good) begin m_pend = int'(cfg_div_i); m_pend_vld = 1; end
        if (en_i) m_stop = 0;
        else if (bnd) m_active = 0;
      end else if (m_pend_vld) begin
        if (bnd) begin
          m_ratio = m_pend; m_pend_vld = 0;
          if (!en_i) m_stop = 1;
        end
      end else begin
        if (good) begin m_pend = int'(cfg_div_i); m_pend_vld = 1; end
        if (!en_i) m_stop = 1;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic c, t;
    c = m_active && (m_pos >= m_ratio / 2);
    t = m_active && (m_pos == m_ratio / 2);
    return {c, t, m_active, ~m_pend_vld, m_err};
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    model_reset();
    #3;
    obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
    n_chk++;
    if (obs !== 5'b00010) begin n_fail++; $display("FAIL reset_outputs got=%b exp=00010", obs); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
    n_chk++;
    if (obs !== 5'b00010) begin n_fail++; $display("FAIL reset_release got=%b exp=00010", obs); end
  endtask

  task automatic test_start();
    logic [4:0] obs;
    int highs = 0, ticks = 0, first = -1;
    en_i = 1'b1;
    cycle();
    n_chk++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL start_busy got=%b exp=1", busy_o); end
    for (int i = 0; i < 20; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL start cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      if (clk_o === 1'b1 && first < 0) first = i;
      highs += int'(clk_o); ticks += int'(tick_o);
      cycle();
    end
    n_chk++;
    if (first != 5) begin n_fail++; $display("FAIL start_first_rise got=%0d exp=5", first); end
    n_chk++;
    if (highs != 10) begin n_fail++; $display("FAIL start_high_cycles got=%0d exp=10", highs); end
    n_chk++;
    if (ticks != 2) begin n_fail++; $display("FAIL start_ticks got=%0d exp=2", ticks); end
  endtask

  task automatic test_ratio_change();
    logic [4:0] obs;
    int w = 0, highs = 0, ticks = 0;
    for (int i = 0; i < 3; i++) cycle();
    cfg_valid_i = 1'b1; cfg_div_i = N'(4);
    cycle();
    cfg_valid_i = 1'b0;
    n_chk++;
    if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL chg_ready_low got=%b exp=0", cfg_ready_o); end
    while (cfg_ready_o !== 1'b1 && w < 20) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL chg_wait cyc=%0d got=%b exp=%b", w, obs, model_out()); end
      cycle(); w++;
    end
    n_chk++;
    if (w != 6) begin n_fail++; $display("FAIL chg_wait_len got=%0d exp=6", w); end
    for (int i = 0; i < 12; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL chg_new cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      highs += int'(clk_o); ticks += int'(tick_o);
      cycle();
    end
    n_chk++;
    if (highs != 6 || ticks != 3) begin n_fail++; $display("FAIL chg_d4_shape got=%0d/%0d exp=6/3", highs, ticks); end
  endtask

  task automatic test_odd_and_err();
    logic [4:0] obs;
    int w = 0, highs = 0, ticks = 0, first = -1;
    cfg_valid_i = 1'b1; cfg_div_i = N'(5);
    cycle();
    cfg_valid_i = 1'b0;
    while (cfg_ready_o !== 1'b1 && w < 20) begin cycle(); w++; end
    n_chk++;
    if (w != 3) begin n_fail++; $display("FAIL odd_wait_len got=%0d exp=3", w); end
    for (int i = 0; i < 10; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL odd cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      if (clk_o === 1'b1 && first < 0) first = i;
      highs += int'(clk_o); ticks += int'(tick_o);
      cycle();
    end
    n_chk++;
    if (first != 2 || highs != 6 || ticks != 2) begin
      n_fail++; $display("FAIL odd_d5_shape got=%0d/%0d/%0d exp=2/6/2", first, highs, ticks);
    end
    cfg_valid_i = 1'b1; cfg_div_i = N'(1);
    cycle();
    cfg_valid_i = 1'b0;
    n_chk++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_pulse got=%b exp=1", err_o); end
    n_chk++;
    if (cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL err_ready got=%b exp=1", cfg_ready_o); end
    cycle();
    n_chk++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got=%b exp=0", err_o); end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL err_keep cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      highs += int'(clk_o);
      cycle();
    end
    n_chk++;
    if (highs != 6) begin n_fail++; $display("FAIL err_ratio_kept got=%0d exp=6", highs); end
  endtask

  task automatic test_stop_restart();
    logic [4:0] obs;
    int w = 0, highs = 0, idles = 0;
    cfg_valid_i = 1'b1; cfg_div_i = N'(8);
    cycle();
    cfg_valid_i = 1'b0;
    while (cfg_ready_o !== 1'b1 && w < 20) begin cycle(); w++; end
    for (int i = 0; i < 3; i++) cycle();
    en_i = 1'b0;
    cycle();
    w = 0;
    while (busy_o === 1'b1 && w < 20) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL stop cyc=%0d got=%b exp=%b", w, obs, model_out()); end
      cycle(); w++;
    end
    n_chk++;
    if (w != 4 || clk_o !== 1'b0) begin n_fail++; $display("FAIL stop_len got=%0d clk=%b exp=4 clk=0", w, clk_o); end
    en_i = 1'b1; cycle();
    for (int i = 0; i < 3; i++) cycle();
    en_i = 1'b0; cycle();
    for (int i = 0; i < 2; i++) cycle();
    en_i = 1'b1; cycle();
    for (int i = 0; i < 16; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL restart cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      highs += int'(clk_o); idles += int'(!busy_o);
      cycle();
    end
    n_chk++;
    if (highs != 8 || idles != 0) begin n_fail++; $display("FAIL restart_gapless got=%0d/%0d exp=8/0", highs, idles); end
  endtask

  task automatic test_boundary_xfer();
    logic [4:0] obs;
    int w = 0, highs = 0, ticks = 0;
    cfg_valid_i = 1'b1; cfg_div_i = N'(6);
    cycle();
    cfg_valid_i = 1'b0;
    while (cfg_ready_o !== 1'b1 && w < 20) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL bnd_wait cyc=%0d got=%b exp=%b", w, obs, model_out()); end
      cycle(); w++;
    end
    n_chk++;
    if (w != 8) begin n_fail++; $display("FAIL bnd_wait_len got=%0d exp=8", w); end
    for (int i = 0; i < 12; i++) begin
      highs += int'(clk_o); ticks += int'(tick_o);
      cycle();
    end
    n_chk++;
    if (highs != 6 || ticks != 2) begin n_fail++; $display("FAIL bnd_d6_shape got=%0d/%0d exp=6/2", highs, ticks); end
  endtask

  task automatic test_idle_xfer_en();
    logic [4:0] obs;
    int w = 0, highs = 0, first = -1;
    en_i = 1'b0;
    while (busy_o === 1'b1 && w < 40) begin cycle(); w++; end
    n_chk++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_reach got=%b exp=0", busy_o); end
    cfg_valid_i = 1'b1; cfg_div_i = N'(3); en_i = 1'b1;
    cycle();
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL idle_xfer cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      if (clk_o === 1'b1 && first < 0) first = i;
      highs += int'(clk_o);
      cycle();
    end
    n_chk++;
    if (first != 1 || highs != 6) begin n_fail++; $display("FAIL idle_xfer_d3 got=%0d/%0d exp=1/6", first, highs); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    int w = 0, highs = 0, first = -1;
    while (clk_o !== 1'b1 && w < 20) begin cycle(); w++; end
    rst_i = 1'b0;
    #2;
    obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
    n_chk++;
    if (obs !== 5'b00010) begin n_fail++; $display("FAIL rst_mid_outputs got=%b exp=00010", obs); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_reset();
    cycle();
    for (int i = 0; i < 10; i++) begin
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL rst_after cyc=%0d got=%b exp=%b", i, obs, model_out()); end
      if (clk_o === 1'b1 && first < 0) first = i;
      highs += int'(clk_o);
      cycle();
    end
    n_chk++;
    if (first != 5 || highs != 5) begin n_fail++; $display("FAIL rst_div_rst got=%0d/%0d exp=5/5", first, highs); end
  endtask

  task automatic test_random();
    logic [4:0] obs;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) en_i = ~en_i;
      cfg_valid_i = ($urandom_range(0, 7) == 0);
      cfg_div_i   = N'($urandom_range(0, 12));
      cycle();
      obs = {clk_o, tick_o, busy_o, cfg_ready_o, err_o};
      n_chk++;
      if (obs !== model_out()) begin n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, model_out()); end
    end
    cfg_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_ratio_change();
    test_odd_and_err();
    test_stop_restart();
    test_boundary_xfer();
    test_idle_xfer_en();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
